// File: rtl/cache_fill_arbiter.sv
// -----------------------------------------------------------------------------
// cache_fill_arbiter
//
// Shares the single off-chip DRAM port between the I-cache and D-cache memory
// systems. One requester owns the port per transaction. A transaction is either
// a BLOCK_WORDS-beat miss fill or a single-beat D-side write-through. Ties are
// resolved round-robin against the side that was served last.
//
// Ports
//   clk               in   1       system clock, all state on rising edge
//   rst               in   1       asynchronous, active-high reset
//   i_req             in   1       I-cache fill request
//   i_addr            in   ADDR_W  I-cache off-chip address
//   i_data_valid      out  1       DRAM beat strobe steered to the I-cache
//   d_req             in   1       D-cache request (fill or write-through)
//   d_wr              in   1       1 = write-through, 0 = fill (sampled at grant)
//   d_addr            in   ADDR_W  D-cache off-chip address
//   d_wdata           in   DATA_W  D-cache write-through data
//   d_data_valid      out  1       DRAM beat strobe steered to the D-cache
//   mem_enable        out  1       DRAM access enable
//   mem_wr            out  1       DRAM write enable
//   mem_addr          out  ADDR_W  DRAM address
//   mem_wdata         out  DATA_W  DRAM write data
//   memory_data_valid in   1       DRAM beat-valid strobe
//   grant_i           out  1       I-cache currently owns the port
//   grant_d           out  1       D-cache currently owns the port
// -----------------------------------------------------------------------------
module cache_fill_arbiter #(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 16,
   parameter int BLOCK_WORDS = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_data_valid,
   input  logic              d_req,
   input  logic              d_wr,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_data_valid,
   output logic              mem_enable,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              memory_data_valid,
   output logic              grant_i,
   output logic              grant_d
);

   // One extra bit so the counter can hold BLOCK_WORDS itself.
   localparam int CNT_W = $clog2(BLOCK_WORDS) + 1;

   localparam logic [CNT_W-1:0]  C_CNT_ZERO   = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]  C_FILL_BEATS = CNT_W'(BLOCK_WORDS);
   localparam logic [CNT_W-1:0]  C_WR_BEATS   = CNT_W'(1);
   localparam logic [ADDR_W-1:0] C_ADDR_ZERO  = {ADDR_W{1'b0}};
   localparam logic [DATA_W-1:0] C_DATA_ZERO  = {DATA_W{1'b0}};

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SERVE_I = 2'd1,
      S_SERVE_D = 2'd2,
      S_TURN    = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_last_d;
   logic             w_last_d_nxt;
   logic [CNT_W-1:0] r_beat_cnt;
   logic [CNT_W-1:0] w_beat_cnt_nxt;
   logic             r_d_wr;
   logic             w_d_wr_nxt;

   logic             w_serve_i;
   logic             w_serve_d;
   logic             w_beat;
   logic [CNT_W-1:0] w_beat_sum;
   logic [CNT_W-1:0] w_target;
   logic             w_done;
   logic             w_owner_req;

   // State decode, beat accounting and completion detection.
   always_comb begin
      w_serve_i   = (r_state == S_SERVE_I);
      w_serve_d   = (r_state == S_SERVE_D);
      // Strobes outside a serve state are never counted.
      w_beat      = memory_data_valid & (w_serve_i | w_serve_d);
      w_beat_sum  = r_beat_cnt + {{(CNT_W-1){1'b0}}, w_beat};
      // Write-through length uses the d_wr value latched at grant time.
      if (w_serve_d && r_d_wr) begin
         w_target = C_WR_BEATS;
      end else begin
         w_target = C_FILL_BEATS;
      end
      w_done      = w_beat & (w_beat_sum == w_target);
      if (w_serve_i) begin
         w_owner_req = i_req;
      end else begin
         w_owner_req = d_req;
      end
   end

   // Next-state logic: arbitration, completion, abort and turnaround.
   always_comb begin
      w_state_nxt    = r_state;
      w_last_d_nxt   = r_last_d;
      w_beat_cnt_nxt = r_beat_cnt;
      w_d_wr_nxt     = r_d_wr;
      case (r_state)
         S_IDLE: begin
            w_beat_cnt_nxt = C_CNT_ZERO;
            if (i_req && d_req) begin
               // Contention: serve the side that did not go last.
               if (r_last_d) begin
                  w_state_nxt = S_SERVE_I;
                  w_d_wr_nxt  = 1'b0;
               end else begin
                  w_state_nxt = S_SERVE_D;
                  w_d_wr_nxt  = d_wr;
               end
            end else if (i_req) begin
               w_state_nxt = S_SERVE_I;
               w_d_wr_nxt  = 1'b0;
            end else if (d_req) begin
               w_state_nxt = S_SERVE_D;
               w_d_wr_nxt  = d_wr;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_SERVE_I, S_SERVE_D: begin
            if (w_done) begin
               w_state_nxt    = S_TURN;
               w_last_d_nxt   = w_serve_d;
               w_beat_cnt_nxt = C_CNT_ZERO;
            end else if (!w_owner_req) begin
               // Owner withdrew: beats already strobed stay delivered.
               w_state_nxt    = S_TURN;
               w_beat_cnt_nxt = C_CNT_ZERO;
            end else begin
               w_beat_cnt_nxt = w_beat_sum;
            end
         end
         S_TURN: begin
            w_state_nxt    = S_IDLE;
            w_beat_cnt_nxt = C_CNT_ZERO;
         end
         default: begin
            w_state_nxt    = S_IDLE;
            w_beat_cnt_nxt = C_CNT_ZERO;
         end
      endcase
   end

   // State, round-robin pointer, beat counter and latched write flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_last_d   <= 1'b0;
         r_beat_cnt <= C_CNT_ZERO;
         r_d_wr     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_last_d   <= w_last_d_nxt;
         r_beat_cnt <= w_beat_cnt_nxt;
         r_d_wr     <= w_d_wr_nxt;
      end
   end

   // Port outputs decoded from the registered state; address, data and beat
   // strobes pass straight through so per-word updates reach DRAM that cycle.
   always_comb begin
      grant_i      = w_serve_i;
      grant_d      = w_serve_d;
      mem_enable   = w_serve_i | w_serve_d;
      mem_wr       = w_serve_d & r_d_wr;
      i_data_valid = memory_data_valid & w_serve_i;
      d_data_valid = memory_data_valid & w_serve_d;
      if (w_serve_i) begin
         mem_addr = i_addr;
      end else if (w_serve_d) begin
         mem_addr = d_addr;
      end else begin
         mem_addr = C_ADDR_ZERO;
      end
      if (w_serve_d) begin
         mem_wdata = d_wdata;
      end else begin
         mem_wdata = C_DATA_ZERO;
      end
   end

endmodule
